// File: rtl/uart_pkg.sv
// Shared UART definitions: default data width and the transmit-queue FSM encoding.
package uart_pkg;

    localparam int UART_D_BITS = 8;

    typedef enum logic [1:0] {
        TXQ_IDLE  = 2'd0,
        TXQ_START = 2'd1,
        TXQ_WAIT  = 2'd2
    } txq_state_t;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock circular FIFO with occupancy counter; rd_data shows the head word combinationally.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int D_BITS    = UART_D_BITS,
    parameter int ADDR_BITS = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [D_BITS-1:0]    wr_data,
    input  logic                 rd_en,
    output logic [D_BITS-1:0]    rd_data,
    output logic                 full,
    output logic                 empty,
    output logic [ADDR_BITS:0]   count
);

    localparam int DEPTH = 2 ** ADDR_BITS;
    localparam logic [ADDR_BITS:0] DEPTH_CNT = (ADDR_BITS + 1)'(DEPTH);

    logic [D_BITS-1:0]    ram [DEPTH];
    logic [ADDR_BITS-1:0] wr_ptr;
    logic [ADDR_BITS-1:0] rd_ptr;
    logic                 wr_ok;
    logic                 rd_ok;

    // A write against a full FIFO is refused even if a pop frees a slot this cycle.
    assign wr_ok   = wr_en && !full;
    assign rd_ok   = rd_en && !empty;
    assign full    = (count == DEPTH_CNT);
    assign empty   = (count == '0);
    assign rd_data = ram[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            ram[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + ADDR_BITS'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + ADDR_BITS'(1);
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + (ADDR_BITS + 1)'(1);
                2'b01:   count <= count - (ADDR_BITS + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_queue.sv
// Buffered UART transmit front-end: FIFO plus a hand-off FSM driving tx_din/tx_start.
// Optional sticky overflow flag with clear input when UART_TXQ_OVERFLOW_EN is defined.
module uart_tx_queue
    import uart_pkg::*;
#(
    parameter int D_BITS    = UART_D_BITS,
    parameter int ADDR_BITS = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [D_BITS-1:0]    wr_data,
    input  logic                 wr_en,
    output logic                 full,
    output logic                 empty,
    output logic [ADDR_BITS:0]   count,
    output logic                 busy,
    output logic [D_BITS-1:0]    tx_din,
    output logic                 tx_start,
    input  logic                 tx_done_tick
`ifdef UART_TXQ_OVERFLOW_EN
    ,
    input  logic                 ovf_clr,
    output logic                 overflow
`endif
);

    txq_state_t        state;
    logic              pop;
    logic [D_BITS-1:0] head_data;

    assign pop = (state == TXQ_IDLE) && !empty;

    uart_sync_fifo #(
        .D_BITS    (D_BITS),
        .ADDR_BITS (ADDR_BITS)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (pop),
        .rd_data (head_data),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= TXQ_IDLE;
            tx_din   <= '0;
            tx_start <= 1'b0;
            busy     <= 1'b0;
        end else begin
            case (state)
                TXQ_IDLE: begin
                    tx_start <= 1'b0;
                    if (!empty) begin
                        tx_din   <= head_data;
                        tx_start <= 1'b1;
                        busy     <= 1'b1;
                        state    <= TXQ_START;
                    end
                end
                TXQ_START: begin
                    tx_start <= 1'b0;
                    state    <= TXQ_WAIT;
                end
                TXQ_WAIT: begin
                    if (tx_done_tick) begin
                        busy  <= 1'b0;
                        state <= TXQ_IDLE;
                    end
                end
                default: begin
                    tx_start <= 1'b0;
                    busy     <= 1'b0;
                    state    <= TXQ_IDLE;
                end
            endcase
        end
    end

`ifdef UART_TXQ_OVERFLOW_EN
    // Set has priority over clear so a same-cycle drop is never lost.
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (wr_en && full) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end
`endif

endmodule

// File: doc/uart_tx_queue.md
# uart_tx_queue

Buffered transmit front-end for the UART: accepts bytes from the host side through a FIFO and drains them one at a time into the UART transmitter (`tx_din`/`tx_start`), waiting for `tx_done_tick` between bytes. Sits directly upstream of the transmitter port of the combined UART. It shares `s_tick`-independent clocking and the same reset with that UART. It lets the host burst up to DEPTH bytes without polling transmitter status.

## Interface
- `D_BITS`, 8, data word width; must match the transmitter's `D_BITS`.
- `ADDR_BITS`, 4, FIFO address width; DEPTH = 2**ADDR_BITS (default 16).
- `clk`  in  1  system clock; single clock domain, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `wr_data`  in  D_BITS  byte to enqueue.
- `wr_en`  in  1  enqueue request; accepted iff `full`=0 in the same cycle.
- `full`  out  1  FIFO holds DEPTH words.
- `empty`  out  1  FIFO holds 0 words.
- `count`  out  ADDR_BITS+1  current FIFO occupancy, 0..DEPTH.
- `busy`  out  1  FSM not in IDLE (a byte is handed off or being sent).
- `tx_din`  out  D_BITS  byte to the transmitter; registered.
- `tx_start`  out  1  one-cycle start pulse to the transmitter.
- `tx_done_tick`  in  1  one-cycle pulse from the transmitter at end of stop bit.
- `overflow`, `ovf_clr`: present only with `UART_TXQ_OVERFLOW_EN` (see Configuration).

## Operation
- Storage: circular buffer, write pointer and read pointer each ADDR_BITS wide, wrap modulo DEPTH; occupancy counter ADDR_BITS+1 wide.
- `full` = (`count` == DEPTH), `empty` = (`count` == 0), both derived from the registered counter.
- Write: when `wr_en`=1 and `full`=0, store `wr_data` at the write pointer, advance it. A write with `full`=1 is dropped silently. Pointers and contents are unchanged.
- Pop: performed only by the FSM on the IDLE->START transition.
- Simultaneous write and pop in one cycle: both take effect, and `count` is unchanged. A write while `full`=1 is rejected even if a pop occurs in the same cycle.
- FSM states:
  - IDLE: if `empty`=0, load `tx_din` from the read pointer, advance the read pointer, and go to START.
  - START: `tx_start`=1 for exactly this cycle; next state is WAIT.
  - WAIT: hold `tx_din`; on `tx_done_tick`=1, go to IDLE.
- `tx_done_tick` in IDLE or START is ignored.
- `tx_din` is held stable from START until the next pop.

## Timing
- Reset values: `tx_din`=0, `tx_start`=0, `busy`=0, `count`=0, `empty`=1, `full`=0, pointers=0, FSM=IDLE, `overflow`=0. RAM contents are don't-care.
- Reset mid-operation aborts any pending byte and clears the queue. The transmitter is reset by the same `reset`.
- Latency into an empty, idle queue:
  - `wr_en` in cycle t.
  - `empty`=0 in cycle t+1; pop at the end of t+1.
  - `tx_start`=1 with valid `tx_din` in cycle t+2.
- Back-to-back bytes: `tx_done_tick` in cycle d puts the FSM in IDLE in d+1. The next `tx_start` is in d+2 if the queue is non-empty.
- `busy`=1 in START and WAIT.

## Configuration
- `UART_TXQ_OVERFLOW_EN` defined:
  - Adds output `overflow` (1 bit, sticky): set on any cycle with `wr_en`=1 and `full`=1.
  - Adds input `ovf_clr` (1 bit): clears `overflow` synchronously. If set and clear occur in the same cycle, set wins.
- Not defined: ports `overflow` and `ovf_clr` are absent, and rejected writes leave no trace.

## Structure
- Shared package `uart_pkg`: FSM state encoding (`TXQ_IDLE`, `TXQ_START`, `TXQ_WAIT`) and default data width constant `UART_D_BITS`=8.
- One sub-module `uart_sync_fifo`: storage, pointers, counter, `full`/`empty`/`count`, with a `rd_en` strobe. The queue FSM and `tx_din`/`tx_start` registers live in the top of `uart_tx_queue`.

## Test plan
- Reset then idle: no writes for 50 cycles -> `tx_start` never asserted, `empty`=1, `count`=0, `tx_din`=0.
- Single byte: write 0xA5 at cycle t -> `tx_start` pulse in t+2 with `tx_din`=0xA5. Pulse `tx_done_tick` 20 cycles later -> `busy`=0 one cycle after, no further `tx_start`.
- Ordering: burst-write 0x01..0x05 in consecutive cycles, acknowledging each byte with `tx_done_tick` -> five `tx_start` pulses carrying 0x01..0x05 in order. Each pulse follows the previous `tx_done_tick` by exactly 2 cycles.
- Full/overflow (DEPTH=16, transmitter stalled in WAIT):
  - Write 18 bytes -> first pops to `tx_din`, then `count`=16, `full`=1.
  - 18th byte is dropped; with the macro, `overflow`=1 until `ovf_clr`.
- Simultaneous write and pop at `count`=3 -> `count` stays 3, data order preserved. Pointer wrap after 40 bytes -> order still correct.
- Reset in WAIT with `count`=5 -> next cycle `count`=0, FSM IDLE, `tx_start`=0. A subsequent stray `tx_done_tick` causes no `tx_start`.
